// File: rtl/pdm_audio_out.sv
// pdm_audio_out: FIFO-buffered PCM-to-PDM transmitter using a first-order sigma-delta modulator
// and its own divided bit clock. Each PCM sample is held for OSR PDM bits.
module pdm_audio_out #(
    parameter int DATA_W     = 8,
    parameter int OSR        = 10,
    parameter int CLK_DIV    = 40,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [DATA_W-1:0]             pcm_data,
    input  logic                          pcm_data_valid,
    output logic                          pcm_data_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          pdm_clk,
    output logic                          pdm_data,
    output logic                          bit_strobe,
    output logic                          underrun
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = $clog2(OSR);
    localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [DW-1:0]     div_cnt, div_nxt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] acc, sample_reg;
    logic [DATA_W:0]   sum;
    logic              wr, tick, load, empty, pop;

    assign pcm_data_ready = fifo_level != (AW+1)'(FIFO_DEPTH);
    assign empty          = fifo_level == '0;
    assign wr             = pcm_data_valid && pcm_data_ready;
    assign tick           = enable && div_cnt == DW'(CLK_DIV-1);
    assign load           = tick && bit_cnt == BW'(OSR-1);
    assign pop            = load && !empty;
    assign div_nxt        = tick ? '0 : div_cnt + 1'b1;
    // carry out of the accumulator is the PDM bit
    assign sum            = {1'b0, acc} + {1'b0, sample_reg};

    always_ff @(posedge clk)
        if (wr) mem[wr_ptr] <= pcm_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            div_cnt    <= '0;
            bit_cnt    <= BW'(OSR-1);
            acc        <= '0;
            sample_reg <= MID;
            pdm_clk    <= 1'b0;
            pdm_data   <= 1'b0;
            bit_strobe <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= fifo_level + (AW+1)'(wr) - (AW+1)'(pop);
            bit_strobe <= tick;
            underrun   <= load && empty;
            if (!enable) begin
                div_cnt    <= '0;
                pdm_clk    <= 1'b0;
                pdm_data   <= 1'b0;
                bit_cnt    <= BW'(OSR-1);
                acc        <= '0;
                sample_reg <= MID;
            end else begin
                div_cnt <= div_nxt;
                pdm_clk <= div_nxt < DW'(CLK_DIV/2);
                if (tick) begin
                    pdm_data <= sum[DATA_W];
                    acc      <= sum[DATA_W-1:0];
                    bit_cnt  <= load ? '0 : bit_cnt + 1'b1;
                    // the bit above used the old sample; the new one governs the next OSR bits
                    if (load) sample_reg <= empty ? MID : mem[rd_ptr];
                end
            end
        end
    end
endmodule
